// File: rtl/bsg_tag_pkg.sv
// Shared definitions for the tag trace replayer and the scripts that build its
// trace ROMs: opcode encoding, entry layout macro and width helpers.
//
// Entry layout, MSB to LSB: opcode[3:0], master mask, client id,
// data_not_reset, len, payload.

`define BSG_TAG_ENTRY_S(name, nm, lgc, lgl, mw) \
    typedef struct packed {                   \
        logic [3:0]     op;                   \
        logic [nm-1:0]  mask;                 \
        logic [lgc-1:0] client;               \
        logic           dnr;                  \
        logic [lgl-1:0] len;                  \
        logic [mw-1:0]  payload;              \
    } name

package bsg_tag_pkg;

    typedef enum logic [3:0] {
        op_finish = 4'd0,
        op_send   = 4'd1,
        op_wait   = 4'd2,
        op_loop   = 4'd3
    } bsg_tag_op_e;

    function automatic int lg_clients(input int num_clients);
        return $clog2(num_clients);
    endfunction

    function automatic int lg_len(input int max_payload_width);
        return $clog2(max_payload_width + 1);
    endfunction

    function automatic int rom_data_width(input int num_masters, input int num_clients,
                                          input int max_payload_width);
        return 4 + num_masters + lg_clients(num_clients) + 1
               + lg_len(max_payload_width) + max_payload_width;
    endfunction

    // Longest packet on the wire: valid bit, header fields, full payload.
    function automatic int packet_width(input int num_clients, input int max_payload_width);
        return 2 + lg_clients(num_clients) + lg_len(max_payload_width) + max_payload_width;
    endfunction

endpackage

// File: rtl/bsg_tag_serial_replay_if.sv
// Trace ROM bus between the replayer (master) and the ROM (slave).
//   addr : ROM word address, driven by the replayer
//   data : ROM word, combinational in addr
interface bsg_tag_serial_replay_if #(
    parameter int addr_width_p = 12,
    parameter int data_width_p = 33
);
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] data;

    modport master (output addr, input data);
    modport slave  (input addr, output data);
endinterface

// File: rtl/bsg_tag_serial_replay_shifter.sv
// Parallel-load, LSB-first shift register with a down-counter of remaining
// bits and a flag marking the last bit.
//   load_i  : capture data_i and count_i (count_i = number of bits - 1)
//   shift_i : advance one bit
//   bit_o   : current bit
//   last_o  : current bit is the final one
module bsg_tag_serial_replay_shifter
    import bsg_tag_pkg::*;
#(
    parameter int width_p       = 28,
    parameter int count_width_p = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     load_i,
    input  logic                     shift_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [count_width_p-1:0] count_i,
    output logic                     bit_o,
    output logic                     last_o
);

    logic [width_p-1:0]       shreg;
    logic [count_width_p-1:0] count;

    always_ff @(posedge clk_i) begin
        if (load_i)
            shreg <= data_i;
        else if (shift_i)
            shreg <= shreg >> 1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count <= '0;
        else if (load_i)
            count <= count_i;
        else if (shift_i && (count != '0))
            count <= count - count_width_p'(1);
    end

    assign bit_o  = shreg[0];
    assign last_o = (count == '0);

endmodule

// File: rtl/bsg_tag_serial_replay.sv
// Replays a trace ROM as bsg_tag serial packets.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   en_i             : run enable; low freezes all progress
//   loops_i          : extra trace passes, captured while in reset
//   rom              : trace ROM bus (address out, entry in)
//   tag_data_o       : registered serial tag bit
//   tag_en_o         : registered per-master enable qualifying tag_data_o
//   done_o, error_o  : sticky completion / illegal-entry flags
module bsg_tag_serial_replay
    import bsg_tag_pkg::*;
#(
    parameter int num_masters_p       = 2,
    parameter int num_clients_p       = 32,
    parameter int max_payload_width_p = 16,
    parameter int rom_addr_width_p    = 12,
    parameter int loop_width_p        = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic [loop_width_p-1:0]  loops_i,
    bsg_tag_serial_replay_if.master  rom,
    output logic                     tag_data_o,
    output logic [num_masters_p-1:0] tag_en_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam int lg_clients_lp = lg_clients(num_clients_p);
    localparam int lg_len_lp     = lg_len(max_payload_width_p);
    localparam int pkt_width_lp  = packet_width(num_clients_p, max_payload_width_p);
    localparam int cnt_width_lp  = $clog2(pkt_width_lp);

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_fetch = 3'd1;
    localparam logic [2:0] st_send  = 3'd2;
    localparam logic [2:0] st_wait  = 3'd3;
    localparam logic [2:0] st_done  = 3'd4;
    localparam logic [2:0] st_err   = 3'd5;

    `BSG_TAG_ENTRY_S(entry_s, num_masters_p, lg_clients_lp, lg_len_lp, max_payload_width_p);

    entry_s                           entry;
    logic [2:0]                       state;
    logic [rom_addr_width_p-1:0]      addr_r;
    logic [loop_width_p-1:0]          loop_cnt;
    logic [max_payload_width_p-1:0]   wait_cnt;
    logic [num_masters_p-1:0]         mask_r;
    logic [pkt_width_lp-1:0]          pkt;
    logic [cnt_width_lp-1:0]          pkt_count;
    logic                             len_ok;
    logic                             load;
    logic                             sending;
    logic                             sh_bit;
    logic                             sh_last;

    assign entry    = rom.data;
    assign rom.addr = addr_r;

    // Packet fields LSB first: valid, client, dnr, len, payload. Payload bits
    // beyond len sit above the counted range and never reach the wire.
    assign pkt       = {entry.payload, entry.len, entry.dnr, entry.client, 1'b1};
    assign pkt_count = cnt_width_lp'(lg_clients_lp + lg_len_lp + 1) + cnt_width_lp'(entry.len);
    assign len_ok    = (int'(entry.len) <= max_payload_width_p);
    assign load      = en_i && (state == st_fetch) && (entry.op == op_send) && len_ok;
    assign sending   = en_i && (state == st_send);

    bsg_tag_serial_replay_shifter #(
        .width_p       (pkt_width_lp),
        .count_width_p (cnt_width_lp)
    ) shifter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (load),
        .shift_i   (sending),
        .data_i    (pkt),
        .count_i   (pkt_count),
        .bit_o     (sh_bit),
        .last_o    (sh_last)
    );

    always_ff @(posedge clk_i) begin
        if (load)
            mask_r <= entry.mask;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= st_idle;
            addr_r   <= '0;
            loop_cnt <= loops_i;
            wait_cnt <= '0;
        end else if (en_i) begin
            case (state)
                st_idle: state <= st_fetch;
                st_fetch: begin
                    case (entry.op)
                        op_finish: state <= st_done;
                        op_send: begin
                            if (len_ok) begin
                                state  <= st_send;
                                addr_r <= addr_r + rom_addr_width_p'(1);
                            end else begin
                                state <= st_err;
                            end
                        end
                        op_wait: begin
                            addr_r <= addr_r + rom_addr_width_p'(1);
                            if (entry.payload != '0) begin
                                wait_cnt <= entry.payload;
                                state    <= st_wait;
                            end
                        end
                        op_loop: begin
                            if (loop_cnt != '0) begin
                                loop_cnt <= loop_cnt - loop_width_p'(1);
                                addr_r   <= '0;
                            end else begin
                                addr_r <= addr_r + rom_addr_width_p'(1);
                            end
                        end
                        default: state <= st_err;
                    endcase
                end
                st_send: if (sh_last) state <= st_fetch;
                st_wait: begin
                    if (wait_cnt == max_payload_width_p'(1))
                        state <= st_fetch;
                    else
                        wait_cnt <= wait_cnt - max_payload_width_p'(1);
                end
                default: state <= state;
            endcase
        end
    end

    // Outputs are registered and forced low on any non-sending cycle; the
    // async reset clears them in the same instant reset asserts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tag_en_o   <= '0;
            tag_data_o <= 1'b0;
        end else begin
            tag_en_o   <= sending ? mask_r : '0;
            tag_data_o <= sending && sh_bit;
        end
    end

    assign done_o  = (state == st_done);
    assign error_o = (state == st_err);

endmodule
